// File: rtl/chunked_serial_adder.sv
// Multi-cycle add/subtract unit: adds CHUNK bits per clock, carry rippled through a register.
// Optional macro CHUNKED_SERIAL_ADDER_ZERO_FLAG_EN adds a registered zero-result flag.
module chunked_serial_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
`ifdef CHUNKED_SERIAL_ADDER_ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);

  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, b_reg, sum_reg;
  logic [IDX_W-1:0] idx_reg;
  logic             cin_reg, carry_reg, overflow_reg;
`ifdef CHUNKED_SERIAL_ADDER_ZERO_FLAG_EN
  logic             zero_reg;
`endif

  logic             accept, last;
  logic [CHUNK-1:0] a_chunk, b_chunk;
  logic [CHUNK:0]   chunk_sum;
  logic [WIDTH-1:0] sum_merged;

  // start is only honoured outside RUN, so DONE can launch a back-to-back operation
  assign accept = start && (state_reg != RUN);
  assign last   = (state_reg == RUN) && (idx_reg == LAST_IDX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last)  state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    a_chunk    = a_reg[idx_reg*CHUNK +: CHUNK];
    b_chunk    = b_reg[idx_reg*CHUNK +: CHUNK];
    chunk_sum  = {1'b0, a_chunk} + {1'b0, b_chunk} + (CHUNK+1)'(cin_reg);
    sum_merged = sum_reg;
    sum_merged[idx_reg*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_reg        <= '0;
      b_reg        <= '0;
      sum_reg      <= '0;
      idx_reg      <= '0;
      cin_reg      <= 1'b0;
      carry_reg    <= 1'b0;
      overflow_reg <= 1'b0;
`ifdef CHUNKED_SERIAL_ADDER_ZERO_FLAG_EN
      zero_reg     <= 1'b0;
`endif
    end else if (accept) begin
      // subtraction is a + ~b + 1, the +1 enters as the initial carry
      a_reg   <= a;
      b_reg   <= sub ? ~b : b;
      cin_reg <= sub;
      idx_reg <= '0;
      sum_reg <= '0;
    end else if (state_reg == RUN) begin
      sum_reg <= sum_merged;
      cin_reg <= chunk_sum[CHUNK];
      idx_reg <= idx_reg + IDX_W'(1);
      if (last) begin
        carry_reg    <= chunk_sum[CHUNK];
        overflow_reg <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                        (chunk_sum[CHUNK-1] != a_reg[WIDTH-1]);
`ifdef CHUNKED_SERIAL_ADDER_ZERO_FLAG_EN
        zero_reg     <= ~|sum_merged;
`endif
      end
    end
  end

  assign busy     = (state_reg == RUN);
  assign done     = (state_reg == DONE);
  assign sum      = sum_reg;
  assign carry    = carry_reg;
  assign overflow = overflow_reg;
`ifdef CHUNKED_SERIAL_ADDER_ZERO_FLAG_EN
  assign zero     = zero_reg;
`endif

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Directed bench for chunked_serial_adder: default 32/4 instance plus an 8/8 single-chunk instance.
module tb_chunked_serial_adder;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, sub;
  logic [31:0] a, b;
  logic        busy, done, carry, overflow;
  logic [31:0] sum;
  logic        s_start, s_sub;
  logic [7:0]  s_a, s_b, s_sum;
  logic        s_busy, s_done, s_carry, s_overflow;
`ifdef CHUNKED_SERIAL_ADDER_ZERO_FLAG_EN
  logic        zero, s_zero;
`endif

  int checks = 0;
  int passes = 0;
  int nbusy, cyc, ndone;

  always #5 clk = ~clk;

  chunked_serial_adder dut (
    .clk(clk), .reset(reset), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .sum(sum), .carry(carry), .overflow(overflow)
`ifdef CHUNKED_SERIAL_ADDER_ZERO_FLAG_EN
    , .zero(zero)
`endif
  );

  chunked_serial_adder #(.WIDTH(8), .CHUNK(8)) dut_small (
    .clk(clk), .reset(reset), .start(s_start), .sub(s_sub), .a(s_a), .b(s_b),
    .busy(s_busy), .done(s_done), .sum(s_sum), .carry(s_carry), .overflow(s_overflow)
`ifdef CHUNKED_SERIAL_ADDER_ZERO_FLAG_EN
    , .zero(s_zero)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Counts busy cycles until done rises (bounded); sampled #1 after each edge.
  task automatic wait_done(input int is_small, output int nb, output int cy);
    nb = 0;
    cy = 0;
    while (((is_small != 0) ? !s_done : !done) && cy < 40) begin
      if ((is_small != 0) ? s_busy : busy) nb++;
      @(posedge clk); #1;
      cy++;
    end
  endtask

  task automatic run_op(input string tag, input logic s, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] esum, input logic ec, input logic ev);
    @(negedge clk);
    sub = s; a = av; b = bv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(0, nbusy, cyc);
    chk({tag, " busy_cycles"}, nbusy, 8);
    chk({tag, " done_latency"}, cyc, 8);
    chk({tag, " sum"}, sum, esum);
    chk({tag, " carry"}, {31'd0, carry}, {31'd0, ec});
    chk({tag, " overflow"}, {31'd0, overflow}, {31'd0, ev});
    $display("op %s sub=%0b a=%h b=%h -> sum=%h c=%0b v=%0b", tag, s, av, bv, sum, carry, overflow);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    s_start = 1'b0; s_sub = 1'b0; s_a = '0; s_b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", {31'd0, busy}, 0);
    chk("reset done", {31'd0, done}, 0);
    chk("reset sum", sum, 0);
    chk("reset flags", {30'd0, carry, overflow}, 0);
    @(negedge clk); reset = 1'b0;

    run_op("add3+1", 1'b0, 32'h0000_0003, 32'h0000_0001, 32'h0000_0004, 1'b0, 1'b0);
    run_op("addwrap", 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0);
`ifdef CHUNKED_SERIAL_ADDER_ZERO_FLAG_EN
    chk("addwrap zero", {31'd0, zero}, 1);
`endif
    run_op("addovf", 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1);
`ifdef CHUNKED_SERIAL_ADDER_ZERO_FLAG_EN
    chk("addovf zero", {31'd0, zero}, 0);
`endif
    run_op("subovf", 1'b1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1);

    // sub 5-7 with start held high and operands changed during RUN
    @(negedge clk);
    sub = 1'b1; a = 32'd5; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    sub = 1'b0; a = 32'h1234_5678; b = 32'h0000_0009;
    wait_done(0, nbusy, cyc);
    chk("sub5-7 busy_cycles", nbusy, 8);
    chk("sub5-7 sum", sum, 32'hFFFF_FFFE);
    chk("sub5-7 carry", {31'd0, carry}, 0);
    chk("sub5-7 overflow", {31'd0, overflow}, 0);
    $display("op sub5-7 held-start -> sum=%h c=%0b v=%0b", sum, carry, overflow);
    // start still high in DONE: back-to-back op latches the changed operands
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b busy_next", {31'd0, busy}, 1);
    chk("b2b done_low", {31'd0, done}, 0);
    wait_done(0, nbusy, cyc);
    chk("b2b done_gap", cyc, 8);
    chk("b2b sum", sum, 32'h1234_5681);
    $display("op b2b a=12345678 b=9 -> sum=%h", sum);
    @(posedge clk); #1;
    chk("b2b done_pulse_one", {31'd0, done}, 0);
    chk("b2b idle", {31'd0, busy}, 0);
    chk("b2b hold sum", sum, 32'h1234_5681);

    run_op("addmin", 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1);

    // reset asserted in the 4th RUN cycle
    @(negedge clk);
    sub = 1'b0; a = 32'h1111_1111; b = 32'h2222_2222; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("mid partial sum", sum, 32'h0000_0333);
    chk("mid busy", {31'd0, busy}, 1);
    reset = 1'b1;
    #1;
    chk("async busy", {31'd0, busy}, 0);
    chk("async done", {31'd0, done}, 0);
    chk("async sum", sum, 0);
    chk("async flags", {30'd0, carry, overflow}, 0);
    @(negedge clk); reset = 1'b0;
    ndone = 0;
    repeat (12) begin @(posedge clk); #1; if (done || busy) ndone++; end
    chk("post-reset no done", ndone, 0);
    $display("op reset-mid-run -> busy=%0b done=%0b sum=%h", busy, done, sum);

    // single-chunk instance
    @(negedge clk);
    s_sub = 1'b0; s_a = 8'h80; s_b = 8'h80; s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    wait_done(1, nbusy, cyc);
    chk("w8 busy_cycles", nbusy, 1);
    chk("w8 done_latency", cyc, 1);
    chk("w8 sum", {24'd0, s_sum}, 0);
    chk("w8 carry", {31'd0, s_carry}, 1);
    chk("w8 overflow", {31'd0, s_overflow}, 1);
    $display("op w8 a=80 b=80 -> sum=%h c=%0b v=%0b", s_sum, s_carry, s_overflow);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
